// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter with full/empty/almost-full status and sticky error flags.
// Optional OCC_EDGE_DETECT_EN: inc/dec are level inputs and each 0->1 transition is one event.
module occupancy_counter #(
   parameter int WIDTH       = 4,
   parameter int CAPACITY    = 15,
   parameter int ALMOST_FULL = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             clear_err,
   output logic [WIDTH-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             rejected,
   output logic             ovf_err,
   output logic             unf_err
);

   generate
      if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
         $error("occupancy_counter: WIDTH must be 2..16");
      end
      if (CAPACITY < 1 || CAPACITY > (1 << WIDTH) - 1) begin : g_bad_capacity
         $error("occupancy_counter: CAPACITY must be 1..2**WIDTH-1");
      end
      if (ALMOST_FULL < 0 || ALMOST_FULL > CAPACITY) begin : g_bad_almost_full
         $error("occupancy_counter: ALMOST_FULL must be 0..CAPACITY");
      end
   endgenerate

   localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);
   localparam logic [WIDTH-1:0] AF_W  = WIDTH'(ALMOST_FULL);
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   logic inc_ev;
   logic dec_ev;

`ifdef OCC_EDGE_DETECT_EN
   logic inc_q;
   logic dec_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inc_q <= 1'b0;
         dec_q <= 1'b0;
      end else begin
         inc_q <= inc;
         dec_q <= dec;
      end
   end

   // Rising-edge decode is combinational so an event adds no latency.
   assign inc_ev = inc & ~inc_q;
   assign dec_ev = dec & ~dec_q;
`else
   assign inc_ev = inc;
   assign dec_ev = dec;
`endif

   logic [WIDTH-1:0] count_nxt;
   logic             ovf_hit;
   logic             unf_hit;

   always_comb begin
      count_nxt = count;
      ovf_hit   = 1'b0;
      unf_hit   = 1'b0;
      // Coincident inc and dec cancel, even at the limits.
      if (inc_ev && !dec_ev) begin
         if (count == CAP_W) begin
            ovf_hit = 1'b1;
         end else begin
            count_nxt = count + ONE_W;
         end
      end else if (dec_ev && !inc_ev) begin
         if (count == '0) begin
            unf_hit = 1'b1;
         end else begin
            count_nxt = count - ONE_W;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         rejected <= 1'b0;
         ovf_err  <= 1'b0;
         unf_err  <= 1'b0;
      end else begin
         count    <= count_nxt;
         rejected <= ovf_hit | unf_hit;
         // A fresh refusal takes priority over a clear in the same cycle.
         ovf_err  <= ovf_hit | (ovf_err & ~clear_err);
         unf_err  <= unf_hit | (unf_err & ~clear_err);
      end
   end

   assign full        = (count == CAP_W);
   assign empty       = (count == '0);
   assign almost_full = (count >= AF_W);

endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
Parametrised up/down occupancy counter. It is the next-generation car-park counter, fed by the entry/exit sensor FSM.
- Adds a configurable width and capacity limit.
- Saturates at 0 and CAPACITY instead of wrapping.
- Resolves simultaneous entry/exit.
- Provides full, empty and almost-full status, plus sticky overflow/underflow error flags for the display and barrier logic.

Parameters:
WIDTH, 4, count width in bits; 2..16.
CAPACITY, 15, maximum occupancy; 1 <= CAPACITY <= 2**WIDTH-1. Elaboration fails otherwise.
ALMOST_FULL, 12, almost_full threshold; 0 <= ALMOST_FULL <= CAPACITY. Elaboration fails otherwise.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
inc  input  1  entry event (car in).
dec  input  1  exit event (car out).
clear_err  input  1  synchronous clear of ovf_err/unf_err.
count  output  WIDTH  current occupancy, registered.
full  output  1  count == CAPACITY.
empty  output  1  count == 0.
almost_full  output  1  count >= ALMOST_FULL.
rejected  output  1  one-cycle pulse: the previous cycle's event was refused.
ovf_err  output  1  sticky: an inc was refused while full.
unf_err  output  1  sticky: a dec was refused while empty.

Behaviour:
- Reset (reset==0, asynchronous assert, synchronous release):
  - count=0, rejected=0, ovf_err=0, unf_err=0.
  - Hence empty=1, full=0, almost_full=(ALMOST_FULL==0).
  - Reset asserted mid-operation overrides everything immediately.
- Each rising clk, with the event decode defined under Optional Feature:
  - inc only, count<CAPACITY: count <= count+1.
  - inc only, count==CAPACITY: count holds; rejected <= 1; ovf_err <= 1.
  - dec only, count>0: count <= count-1.
  - dec only, count==0: count holds; rejected <= 1; unf_err <= 1.
  - inc and dec together: net zero; count holds, no rejection, no error, at any count including 0 and CAPACITY.
  - Neither: count holds; rejected <= 0.
- rejected is high for exactly the cycle after a refused event. It is 0 in every other cycle.
- Arithmetic:
  - No wrap-around. count never leaves 0..CAPACITY.
  - Internal compares at WIDTH bits. CAPACITY and ALMOST_FULL are truncated/cast to WIDTH.
- full, empty and almost_full are decoded combinationally from the count register, so they change in the same cycle as count. No glitch-sensitive use is permitted downstream.
- Error flags:
  - ovf_err and unf_err stay set until clear_err==1 at a clock edge.
  - If clear_err and a new refusal happen in the same cycle, set wins (flag stays 1).
  - clear_err has no effect on count.
- Latency: an event sampled at edge N is visible on count/flags after edge N, and on rejected after edge N.

Optional Feature:
Macro: OCC_EDGE_DETECT_EN
- Defined:
  - inc/dec are level sensor signals.
  - Internal registers inc_q/dec_q hold the previous-cycle value; both reset to 0.
  - Event = input & ~previous, so one event per 0->1 transition and no added latency.
  - A held-high input counts once.
  - The simultaneous-event rule applies to coincident rising edges.
- Undefined:
  - inc/dec are single-cycle event strobes from the FSM.
  - Every cycle an input is high counts as one event.
  - No extra registers.

Test Plan:
1. Reset: drive reset=0 mid-count (count=7), asynchronously between edges -> count=0, empty=1, full=0, errors=0 immediately, without waiting for a clock edge.
2. Fill to capacity (defaults): 15 inc strobes from 0 -> count=15, full=1; almost_full first 1 at count=12. A 16th inc -> count stays 15, rejected=1 for one cycle, ovf_err=1.
3. Underflow: from 0, one dec -> count=0, rejected pulse, unf_err=1. Then clear_err=1 alone -> unf_err=0. clear_err together with another refused dec -> unf_err stays 1.
4. Simultaneous events: inc=dec=1 at count 0, 5 and 15 -> count unchanged (0/5/15), rejected=0, no error flags.
5. Parametrised instance, WIDTH=3, CAPACITY=5, ALMOST_FULL=4: 7 incs -> count=5 (no wrap to 0), two refusals, ovf_err=1; almost_full from count=4.
6. With OCC_EDGE_DETECT_EN: hold inc=1 for 10 cycles -> count=1. Toggle inc 1/0 three times -> count=4. Without the macro, a 10-cycle hold -> count=10.
